// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with a DEPTH-entry output FIFO and flush.
// Defining RV_M_EXT_EN adds RV32M decode and drives mul_div.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  instr,
  input  logic [XLEN-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [15:0]                  op_code,
  output logic [XLEN-1:0]              imm,
  output logic [4:0]                   rs1_sel,
  output logic [4:0]                   rs2_sel,
  output logic [4:0]                   rd_sel,
  output logic                         alu_sel,
  output logic [1:0]                   rd_data_sel,
  output logic                         reg_w,
  output logic                         data_w,
  output logic                         data_r,
  output logic                         unsigned_value,
  output logic                         branch,
  output logic                         load_pc,
  output logic [1:0]                   data_size,
  output logic                         illegal,
  output logic                         mul_div,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [15:0]     op_code;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            alu_sel;
    logic [1:0]      rd_data_sel;
    logic            reg_w;
    logic            data_w;
    logic            data_r;
    logic            unsigned_value;
    logic            branch;
    logic            load_pc;
    logic [1:0]      data_size;
    logic            illegal;
    logic            mul_div;
  } entry_t;

  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, shamt;
  logic [31:0] imm32;
  logic        legal;
  entry_t      dec;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {instr[31:12], 12'b0};
  assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign shamt = {27'b0, instr[24:20]};

  // op_code drops funct7[6], which is zero in every RV32I/RV32M encoding
  always_comb begin
    dec    = '0;
    imm32  = '0;
    legal  = 1'b0;
    dec.pc = in_pc;
    case (opc)
      OPC_LUI: begin
        legal = 1'b1; dec.rd = instr[11:7]; dec.reg_w = 1'b1;
        dec.rd_data_sel = 2'b10; imm32 = u_imm; dec.op_code = {9'b0, opc};
      end
      OPC_AUIPC: begin
        legal = 1'b1; dec.rd = instr[11:7]; dec.reg_w = 1'b1; dec.alu_sel = 1'b1;
        dec.load_pc = 1'b1; imm32 = u_imm; dec.op_code = {9'b0, opc};
      end
      OPC_JAL: begin
        legal = 1'b1; dec.rd = instr[11:7]; dec.reg_w = 1'b1; dec.alu_sel = 1'b1;
        dec.load_pc = 1'b1; dec.rd_data_sel = 2'b11; imm32 = j_imm; dec.op_code = {9'b0, opc};
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000); dec.rd = instr[11:7]; dec.rs1 = instr[19:15];
        dec.reg_w = 1'b1; dec.alu_sel = 1'b1; dec.rd_data_sel = 2'b11;
        imm32 = i_imm; dec.op_code = {6'b0, f3, opc};
      end
      OPC_BRANCH: begin
        legal = (f3 != 3'b010) && (f3 != 3'b011); dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20];
        dec.branch = 1'b1; dec.alu_sel = 1'b1; imm32 = b_imm; dec.op_code = {6'b0, f3, opc};
      end
      OPC_LOAD: begin
        legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.reg_w = 1'b1; dec.alu_sel = 1'b1;
        dec.data_r = 1'b1; dec.rd_data_sel = 2'b01; dec.unsigned_value = f3[2];
        dec.data_size = f3[1:0]; imm32 = i_imm; dec.op_code = {6'b0, f3, opc};
      end
      OPC_STORE: begin
        legal = (f3 < 3'b011); dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20];
        dec.alu_sel = 1'b1; dec.data_w = 1'b1; dec.data_size = f3[1:0];
        imm32 = s_imm; dec.op_code = {6'b0, f3, opc};
      end
      OPC_OPIMM: begin
        dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.reg_w = 1'b1; dec.alu_sel = 1'b1;
        dec.unsigned_value = (f3 == 3'b011);
        if (f3 == 3'b001 || f3 == 3'b101) begin
          legal = (f7 == 7'b0000000) || (f3 == 3'b101 && f7 == 7'b0100000);
          imm32 = shamt; dec.op_code = {f7[5:0], f3, opc};
        end else begin
          legal = 1'b1; imm32 = i_imm; dec.op_code = {6'b0, f3, opc};
        end
      end
      OPC_OP: begin
        dec.rd = instr[11:7]; dec.rs1 = instr[19:15]; dec.rs2 = instr[24:20];
        dec.reg_w = 1'b1; dec.alu_sel = 1'b1; dec.op_code = {f7[5:0], f3, opc};
        legal = (f7 == 7'b0000000) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
`ifdef RV_M_EXT_EN
        if (f7 == 7'b0000001) begin
          legal = 1'b1; dec.mul_div = 1'b1; dec.alu_sel = 1'b0;
        end
`endif
      end
      OPC_MISC: begin
        legal = (f3 == 3'b000); dec.op_code = {6'b0, f3, opc};
      end
      default: legal = 1'b0;
    endcase
    dec.imm = XLEN'($signed(imm32));
    // illegal entries keep their PC so execute can report the faulting address
    if (!legal) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.illegal = 1'b1;
    end
  end

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              push, pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  assign head           = out_valid ? mem[rd_ptr] : '0;
  assign out_pc         = head.pc;
  assign op_code        = head.op_code;
  assign imm            = head.imm;
  assign rs1_sel        = head.rs1;
  assign rs2_sel        = head.rs2;
  assign rd_sel         = head.rd;
  assign alu_sel        = head.alu_sel;
  assign rd_data_sel    = head.rd_data_sel;
  assign reg_w          = head.reg_w;
  assign data_w         = head.data_w;
  assign data_r         = head.data_r;
  assign unsigned_value = head.unsigned_value;
  assign branch         = head.branch;
  assign load_pc        = head.load_pc;
  assign data_size      = head.data_size;
  assign illegal        = head.illegal;
  assign mul_div        = head.mul_div;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage (XLEN=32, DEPTH=2).
module tb_decode_stage;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int NV    = 14;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] op_code;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        alu_sel;
    logic [1:0]  rd_data_sel;
    logic        reg_w;
    logic        data_w;
    logic        data_r;
    logic        unsigned_value;
    logic        branch;
    logic        load_pc;
    logic [1:0]  data_size;
    logic        illegal;
    logic        mul_div;
  } dec_t;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr;
  logic [XLEN-1:0] in_pc, out_pc, imm;
  logic [15:0] op_code;
  logic [4:0] rs1_sel, rs2_sel, rd_sel;
  logic alu_sel, reg_w, data_w, data_r, unsigned_value, branch, load_pc, illegal, mul_div;
  logic [1:0] rd_data_sel, data_size;
  logic [CW-1:0] count;
  dec_t act;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .op_code(op_code), .imm(imm), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rd_sel(rd_sel),
    .alu_sel(alu_sel), .rd_data_sel(rd_data_sel), .reg_w(reg_w), .data_w(data_w),
    .data_r(data_r), .unsigned_value(unsigned_value), .branch(branch), .load_pc(load_pc),
    .data_size(data_size), .illegal(illegal), .mul_div(mul_div), .count(count)
  );

  assign act = {out_pc, op_code, imm, rs1_sel, rs2_sel, rd_sel, alu_sel, rd_data_sel,
                reg_w, data_w, data_r, unsigned_value, branch, load_pc, data_size, illegal, mul_div};

  int checks = 0;
  int errors = 0;
  dec_t  exp_q[$];
  string name_q[$];
  logic [31:0] vi [NV];
  dec_t        ve [NV];
  string       vn [NV];
  dec_t        mon_e;
  string       mon_n;

  task automatic check(string nm, logic [127:0] got, logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // scoreboard monitor: every accepted output beat is compared with the oldest expectation
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got pc=%h instr-decode=%h want none", out_pc, act);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        if (act !== mon_e) begin
          errors++;
          $display("FAIL %s got=%h want=%h", mon_n, act, mon_e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(int idx, logic [31:0] pc);
    dec_t e;
    e = ve[idx];
    e.pc = pc;
    in_valid = 1'b1;
    instr    = vi[idx];
    in_pc    = pc;
    for (int t = 0; t < 50; t++) begin
      if (in_ready) begin
        exp_q.push_back(e);
        name_q.push_back(vn[idx]);
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL send_timeout %s got in_ready=0 want 1", vn[idx]);
  endtask

  task automatic drain(string nm);
    out_ready = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) tick();
    check({nm, "_left"}, exp_q.size(), 0);
    check({nm, "_count"}, count, 0);
  endtask

  task automatic flush_clear;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    name_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

  initial begin
    vi[0]  = 32'hFFF00093; vn[0]  = "addi";
    ve[0]  = '{op_code:16'h0013, imm:32'hFFFFFFFF, rd:5'd1, alu_sel:1'b1, reg_w:1'b1, default:'0};
    vi[1]  = 32'h0020A423; vn[1]  = "sw";
    ve[1]  = '{op_code:16'h0123, imm:32'd8, rs1:5'd1, rs2:5'd2, alu_sel:1'b1, data_w:1'b1, data_size:2'b10, default:'0};
    vi[2]  = 32'h800002B7; vn[2]  = "lui";
    ve[2]  = '{op_code:16'h0037, imm:32'h80000000, rd:5'd5, rd_data_sel:2'b10, reg_w:1'b1, default:'0};
    vi[3]  = 32'hFFC3C303; vn[3]  = "lbu";
    ve[3]  = '{op_code:16'h0203, imm:32'hFFFFFFFC, rs1:5'd7, rd:5'd6, alu_sel:1'b1, rd_data_sel:2'b01,
               reg_w:1'b1, data_r:1'b1, unsigned_value:1'b1, default:'0};
    vi[4]  = 32'hFE208CE3; vn[4]  = "beq";
    ve[4]  = '{op_code:16'h0063, imm:32'hFFFFFFF8, rs1:5'd1, rs2:5'd2, alu_sel:1'b1, branch:1'b1, default:'0};
    vi[5]  = 32'h010000EF; vn[5]  = "jal";
    ve[5]  = '{op_code:16'h006F, imm:32'd16, rd:5'd1, alu_sel:1'b1, rd_data_sel:2'b11, reg_w:1'b1,
               load_pc:1'b1, default:'0};
    vi[6]  = 32'h41F25193; vn[6]  = "srai";
    ve[6]  = '{op_code:16'h8293, imm:32'd31, rs1:5'd4, rd:5'd3, alu_sel:1'b1, reg_w:1'b1, default:'0};
    vi[7]  = 32'h00000000; vn[7]  = "zero_word";
    ve[7]  = '{illegal:1'b1, default:'0};
    vi[8]  = 32'h022081B3; vn[8]  = "mul";
`ifdef RV_M_EXT_EN
    ve[8]  = '{op_code:16'h0433, rs1:5'd1, rs2:5'd2, rd:5'd3, reg_w:1'b1, mul_div:1'b1, default:'0};
`else
    ve[8]  = '{illegal:1'b1, default:'0};
`endif
    vi[9]  = 32'h00513093; vn[9]  = "sltiu";
    ve[9]  = '{op_code:16'h0193, imm:32'd5, rs1:5'd2, rd:5'd1, alu_sel:1'b1, reg_w:1'b1,
               unsigned_value:1'b1, default:'0};
    vi[10] = 32'h0FF0000F; vn[10] = "fence";
    ve[10] = '{op_code:16'h000F, default:'0};
    vi[11] = 32'h00000073; vn[11] = "ecall";
    ve[11] = '{illegal:1'b1, default:'0};
    vi[12] = 32'h40101093; vn[12] = "slli_bad_f7";
    ve[12] = '{illegal:1'b1, default:'0};
    vi[13] = 32'h007302B3; vn[13] = "add";
    ve[13] = '{op_code:16'h0033, rs1:5'd6, rs2:5'd7, rd:5'd5, alu_sel:1'b1, reg_w:1'b1, default:'0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; in_pc = '0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_count", count, 0);
    check("reset_fields", act, '0);

    // one-cycle visibility of a single entry
    send(0, 32'h0);
    check("lat_out_valid", out_valid, 1);
    check("lat_count", count, 1);
    drain("lat");

    // back-to-back stream with execute always ready
    out_ready = 1'b1;
    for (int i = 1; i < NV; i++) send(i, 32'h100 + 32'(4 * (i - 1)));
    drain("stream");

    // fill to DEPTH, third instruction held until a slot frees
    out_ready = 1'b0;
    send(13, 32'h200);
    send(2, 32'h204);
    check("full_in_ready", in_ready, 0);
    check("full_count", count, 2);
    in_valid = 1'b1; instr = vi[5]; in_pc = 32'h208;
    tick(); tick();
    check("held_count", count, 2);
    check("held_in_ready", in_ready, 0);
    out_ready = 1'b1;
    send(5, 32'h208);
    drain("full");

    // flush while full with a presented instruction
    out_ready = 1'b0;
    send(0, 32'h300);
    send(1, 32'h304);
    flush = 1'b1; in_valid = 1'b1; instr = vi[3]; in_pc = 32'h308;
    flush_clear();
    check("flush_full_count", count, 0);
    check("flush_full_out_valid", out_valid, 0);

    // flush with one entry, same-cycle push and pop both discarded
    send(4, 32'h400);
    out_ready = 1'b1;
    flush = 1'b1; in_valid = 1'b1; instr = vi[6]; in_pc = 32'h404;
    flush_clear();
    check("flush_one_count", count, 0);
    check("flush_one_out_valid", out_valid, 0);
    send(9, 32'h500);
    drain("post_flush");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
